// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared types and constants for the player-controller input front end
package input_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } db_state_t;

    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage flop synchroniser with asynchronous reset
// clk       : destination clock
// clean_rst : asynchronous active-high reset, all stages clear to 0
// d         : asynchronous input
// q         : synchronised output (last stage)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clean_rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise and debounce one push-button, with press pulse
// clk       : system clock, rising edge
// clean_rst : asynchronous active-high reset
// btn_in    : raw bouncing button pin
// btn_level : debounced level, 1 = pressed
// btn_pulse : one-cycle pulse on each debounced press
module button_debouncer
    import input_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic clean_rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             raw;
    logic             sync;
    logic [CNT_W-1:0] cnt,   cnt_d;
    db_state_t        state, state_d;
    logic             level_d;
    logic             pulse_d;
    logic             expire;

    // Inverting before the synchroniser keeps reset value 0 meaning "not pressed".
    assign raw = ACTIVE_LOW ? ~btn_in : btn_in;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .clean_rst (clean_rst),
        .d         (raw),
        .q         (sync)
    );

    // Expiry happens on the edge that would otherwise take cnt past STABLE_CYCLES-1,
    // so the new value must be seen on STABLE_CYCLES consecutive edges.
    assign expire = (cnt >= CNT_LAST);

    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            state     <= LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            btn_level <= level_d;
            btn_pulse <= pulse_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        level_d = btn_level;
        pulse_d = 1'b0;
        case (state)
            LOW, RISE_WAIT: begin
                if (!sync) begin
                    state_d = LOW;
                end else if (expire) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    state_d = RISE_WAIT;
                    cnt_d   = cnt + CNT_W'(1);
                end
            end
            HIGH, FALL_WAIT: begin
                if (sync) begin
                    state_d = HIGH;
                end else if (expire) begin
                    state_d = LOW;
                    level_d = 1'b0;
                end else begin
                    state_d = FALL_WAIT;
                    cnt_d   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                level_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

    localparam int SS = 2;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       clean_rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_in_n = 1'b1;
    logic [2:0] lv;
    logic [2:0] pl;

    int vectors = 0;
    int errors  = 0;

    // instance 0: STABLE=4 active-high, 1: STABLE=4 active-low, 2: STABLE=1 active-high
    button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .clean_rst(clean_rst), .btn_in(btn_in), .btn_level(lv[0]), .btn_pulse(pl[0]));
    button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .clean_rst(clean_rst), .btn_in(btn_in_n), .btn_level(lv[1]), .btn_pulse(pl[1]));
    button_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .clean_rst(clean_rst), .btn_in(btn_in), .btn_level(lv[2]), .btn_pulse(pl[2]));

    always #5 clk = ~clk;

    // Model: the level flips on edge k when the synchronised value seen on each
    // of the last N edges (k-N+1..k) differs from the current level. The value
    // seen on edge k is the pressed-state sampled SS edges earlier.
    int  n_stable[NI] = '{4, 4, 1};
    bit  raw_h[NI][0:2047];
    int  ec;
    bit  m_level[NI];
    bit  m_pulse[NI];

    function automatic bit sync_seen(int i, int k);
        if (k - SS < 1) return 1'b0;
        return raw_h[i][k - SS];
    endfunction

    always @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            ec = 0;
            for (int i = 0; i < NI; i++) begin
                m_level[i] = 1'b0;
                m_pulse[i] = 1'b0;
            end
        end else begin
            bit all_diff;
            bit prev;
            ec = ec + 1;
            raw_h[0][ec] = btn_in;
            raw_h[1][ec] = ~btn_in_n;
            raw_h[2][ec] = btn_in;
            for (int i = 0; i < NI; i++) begin
                all_diff = 1'b1;
                for (int j = ec - n_stable[i] + 1; j <= ec; j++)
                    if (sync_seen(i, j) == m_level[i]) all_diff = 1'b0;
                prev = m_level[i];
                if (all_diff) m_level[i] = ~m_level[i];
                m_pulse[i] = !prev && m_level[i];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_level%0d", i), 32'(lv[i]), 32'(m_level[i]));
            chk($sformatf("model_pulse%0d", i), 32'(pl[i]), 32'(m_pulse[i]));
        end
    end

    int t_edge[NI];
    int p_cnt[NI];

    // Counts edges until each level first changes, and pulses seen, over n cycles.
    task automatic measure(input int n);
        logic [2:0] start;
        start = lv;
        for (int i = 0; i < NI; i++) begin
            t_edge[i] = -1;
            p_cnt[i]  = 0;
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (t_edge[i] < 0 && lv[i] != start[i]) t_edge[i] = c;
                if (pl[i]) p_cnt[i]++;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        clean_rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean press held 20 cycles
        btn_in = 1'b1;
        measure(20);
        chk("press_latency", t_edge[0], 6);
        chk("press_pulses", p_cnt[0], 1);
        chk("press_latency_n1", t_edge[2], 3);
        chk("press_pulses_n1", p_cnt[2], 1);

        // release from HIGH
        btn_in = 1'b0;
        measure(12);
        chk("release_latency", t_edge[0], 6);
        chk("release_pulses", p_cnt[0], 0);
        chk("release_latency_n1", t_edge[2], 3);

        // async reset while HIGH with button still held
        btn_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("high_before_reset", 32'(lv[0]), 1);
        #2 clean_rst = 1'b1;
        #1;
        chk("reset_level", 32'(lv), 0);
        chk("reset_pulse", 32'(pl), 0);
        @(negedge clk);
        clean_rst = 1'b0;
        measure(12);
        chk("post_reset_latency", t_edge[0], 6);
        chk("post_reset_pulses", p_cnt[0], 1);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);

        // bounce 1,0,1,0 then hold 1
        btn_in = 1'b1; @(negedge clk);
        btn_in = 1'b0; @(negedge clk);
        btn_in = 1'b1; @(negedge clk);
        btn_in = 1'b0; @(negedge clk);
        chk("bounce_no_change", 32'(lv[0]), 0);
        btn_in = 1'b1;
        measure(12);
        chk("bounce_latency", t_edge[0], 6);
        chk("bounce_pulses", p_cnt[0], 1);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);

        // 3-cycle glitch
        btn_in = 1'b1;
        measure(3);
        chk("glitch_pulses_a", p_cnt[0], 0);
        chk("glitch_edge_a", t_edge[0], -1);
        btn_in = 1'b0;
        measure(10);
        chk("glitch_pulses_b", p_cnt[0], 0);
        chk("glitch_edge_b", t_edge[0], -1);

        // active-low pin
        chk("al_idle_level", 32'(lv[1]), 0);
        btn_in_n = 1'b0;
        measure(12);
        chk("al_press_latency", t_edge[1], 6);
        chk("al_press_pulses", p_cnt[1], 1);
        btn_in_n = 1'b1;
        measure(12);
        chk("al_release_latency", t_edge[1], 6);
        chk("al_release_pulses", p_cnt[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Cleans one raw mechanical push-button (or switch) input for the player-controller front end. The raw input is synchronised into the `clk` domain and debounced by a stability counter. The block produces a debounced level plus a single-cycle press pulse. The controller instantiates one copy per button (up, down, fire, reset) and uses the pulse for lane stepping and the level for held actions.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive cycles the synchronised input must hold a new value before the output follows; legal range ≥ 1.
- `SYNC_STAGES`, default 2: synchroniser depth; legal range ≥ 2.
- `ACTIVE_LOW`, default 0: when 1, the raw input is inverted before synchronisation (pressed = 0 on the pin).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clean_rst`  in  1  reset, asynchronous, active-high.
- `btn_in`  in  1  raw, asynchronous, bouncing button input.
- `btn_level`  out  1  debounced level; 1 = pressed.
- `btn_pulse`  out  1  one-cycle pulse on each debounced 0→1 transition of `btn_level`.

## Operation
- Polarity stage: `raw = ACTIVE_LOW ? ~btn_in : btn_in`.
- Synchroniser: a `SYNC_STAGES`-flop shift register; its last stage is `sync`.
- Counter `cnt`, width `$clog2(STABLE_CYCLES+1)`:
  - `sync == btn_level`: `cnt <= 0`.
  - Otherwise, `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - Otherwise: `btn_level <= sync`, `cnt <= 0`.
- Any single cycle with `sync == btn_level` restarts the count. A glitch or bounce shorter than `STABLE_CYCLES` consecutive cycles never changes `btn_level`.
- State machine, 4 states:
  - `LOW`: `btn_level` = 0, `cnt` = 0. Leaves to `RISE_WAIT` when `sync` = 1.
  - `RISE_WAIT`: counting. Returns to `LOW` if `sync` = 0. Goes to `HIGH` on expiry.
  - `HIGH`: `btn_level` = 1. Leaves to `FALL_WAIT` when `sync` = 0.
  - `FALL_WAIT`: counting. Returns to `HIGH` if `sync` = 1. Goes to `LOW` on expiry.
- `btn_pulse` is registered and asserts for exactly the one cycle in which `btn_level` first reads 1. It never asserts on release. A held button gives exactly one pulse.
- `btn_pulse` and `btn_level` rise on the same edge.

## Timing
- All outputs are registered; there is no combinational path from `btn_in` to any output.
- Reset values: synchroniser flops 0, `cnt` 0, state `LOW`, `btn_level` 0, `btn_pulse` 0.
  - With `ACTIVE_LOW`=1 the flops still reset to 0, which means "not pressed".
- Latency: `raw` is stable from before edge 0. `sync` reflects it after edge `SYNC_STAGES`, and `btn_level` changes on edge `SYNC_STAGES + STABLE_CYCLES`.
  - With the defaults: 2 + STABLE_CYCLES cycles.
- `STABLE_CYCLES` = 1: the output follows `sync` one edge after `sync` differs.
- Reset mid-count or while `HIGH`: all state clears at once.
  - If the button is still held after release of `clean_rst`, it is treated as a new press. `btn_level` rises again after the full latency, with a pulse.
- Consumers sampling on the falling edge of `clk` see each pulse exactly once.

## Structure
- Shared package `input_pkg`:
  - state enum `db_state_t` (`LOW`, `RISE_WAIT`, `HIGH`, `FALL_WAIT`);
  - default `DEBOUNCE_CYCLES` constant, from `CLK_HZ` × 10 ms.
- Sub-module `sync_ff`: a parameterised N-stage synchroniser with async reset. It is instantiated once here and is reusable elsewhere.
- Counter and FSM live in the top `button_debouncer` body.

## Test plan
Use `STABLE_CYCLES`=4 and `SYNC_STAGES`=2 unless noted.
1. Reset: assert `clean_rst` with `btn_in`=1 → `btn_level`=0 and `btn_pulse`=0 immediately (async). After release, `btn_level`=1 on edge 6 with a one-cycle `btn_pulse`.
2. Clean press: `btn_in` 0→1 held for 20 cycles → `btn_level` rises exactly 6 edges later; one `btn_pulse`; no further pulses while held.
3. Bounce: `btn_in` toggles 1,0,1,0 each cycle, then holds 1 → no output change during the toggling; `btn_level` rises 6 edges after the last toggle.
4. Glitch: a 3-cycle high pulse on `btn_in` → `btn_level` stays 0 and `btn_pulse` never asserts.
5. Release: from `HIGH`, `btn_in`→0 → `btn_level` falls 6 edges later; `btn_pulse` stays 0.
6. `ACTIVE_LOW`=1: `btn_in` held 1 → `btn_level` 0. `btn_in`→0 → `btn_level` 1 after 6 edges with one pulse.
